// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EX stage: fixed-latency multiply, 32-step
// restoring divide, mthi/mtlo moves, and ownership of the HI/LO registers.
module mdu_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        mult,
    input  logic        div,
    input  logic        mdsign,
    input  logic [1:0]  hilowen,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        md_stall,
    output logic        md_done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(MUL_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [4:0]  r_step;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_md_done;

    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_rem;
    logic        r_sign;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_idle;
    logic        w_start;
    logic        w_mv;
    logic signed [63:0] w_mul_a;
    logic signed [63:0] w_mul_b;
    logic signed [63:0] w_prod;
    logic [32:0] w_shift;
    logic [31:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_nxt;

    function automatic logic [31:0] f_neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] f_mag(input logic [31:0] v, input logic sgn);
        return f_neg_if(v, sgn & v[31]);
    endfunction

    assign w_idle  = (r_state == S_IDLE);
    assign w_start = resetn && ex_valid && (mult || div) && !flush && w_idle;
    assign w_mv    = resetn && ex_valid && !mult && !div && (|hilowen) && !flush && w_idle;

    assign md_stall = w_start || (r_state == S_MUL) || (r_state == S_DIV) ||
                      (r_state == S_FIX);
    assign md_done  = r_md_done;
    assign hi       = r_hi;
    assign lo       = r_lo;

    assign w_mul_a = {{32{r_sign & r_opa[31]}}, r_opa};
    assign w_mul_b = {{32{r_sign & r_opb[31]}}, r_opb};
    assign w_prod  = w_mul_a * w_mul_b;

    // Restoring step: the remainder always stays below the divisor, so the
    // 33rd bit only matters for the compare, never for the stored remainder.
    assign w_shift   = {r_rem, r_opa[31]};
    assign w_qbit    = (w_shift >= {1'b0, r_opb});
    assign w_diff    = w_shift[31:0] - r_opb;
    assign w_rem_nxt = w_qbit ? w_diff : w_shift[31:0];

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_sign <= mdsign;
            r_rem  <= '0;
            if (mult) begin
                r_opa <= rs_val;
                r_opb <= rt_val;
            end else begin
                r_opa   <= f_mag(rs_val, mdsign);
                r_opb   <= f_mag(rt_val, mdsign);
                r_neg_q <= mdsign & (rs_val[31] ^ rt_val[31]);
                r_neg_r <= mdsign & rs_val[31];
            end
        end else if (r_state == S_DIV) begin
            r_rem <= w_rem_nxt;
            r_opa <= {r_opa[30:0], w_qbit};
        end
    end

    // Flush beats every HI/LO write except in DONE, where the result is committed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_step    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_md_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (mult) begin
                            r_state <= S_MUL;
                            r_cnt   <= CNT_INIT;
                        end else begin
                            r_state <= S_DIV;
                            r_step  <= 5'd31;
                        end
                    end else if (w_mv) begin
                        if (hilowen[1]) r_hi <= rs_val;
                        if (hilowen[0]) r_lo <= rs_val;
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_hi      <= w_prod[63:32];
                        r_lo      <= w_prod[31:0];
                        r_state   <= S_DONE;
                        r_md_done <= 1'b1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (r_step == 5'd0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_step <= r_step - 5'd1;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_lo      <= f_neg_if(r_opa, r_neg_q);
                        r_hi      <= f_neg_if(r_rem, r_neg_r);
                        r_state   <= S_DONE;
                        r_md_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: table of mult/div vectors through a
// scoreboard queue, plus hand-written move, flush and reset sequences.
module tb_mdu_ctrl;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        mult = 1'b0;
    logic        div = 1'b0;
    logic        mdsign = 1'b0;
    logic [1:0]  hilowen = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        md_stall;
    logic        md_done;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .ex_valid (ex_valid),
        .mult     (mult),
        .div      (div),
        .mdsign   (mdsign),
        .hilowen  (hilowen),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_stall (md_stall),
        .md_done  (md_done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_mul;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_run = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        ex_valid = 1'b0;
        mult     = 1'b0;
        div      = 1'b0;
        hilowen  = 2'b00;
        flush    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        int   cyc;
        int   stalls;
        bit   done;
        tick();
        ex_valid = 1'b1;
        mult     = v.is_mul;
        div      = !v.is_mul;
        mdsign   = v.sgn;
        rs_val   = v.a;
        rt_val   = v.b;
        e.hi  = v.hi;
        e.lo  = v.lo;
        e.lat = v.is_mul ? MC + 1 : 34;
        sb.push_back(e);
        cyc = 0;
        stalls = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (md_stall) stalls++;
            if (md_done) begin
                done = 1'b1;
            end else begin
                tick();
                clr();
                cyc++;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            n_run++;
            n_fail++;
            $display("FAIL timeout: md_done not seen within 200 cycles");
        end else begin
            chk("done_cycle", cyc, e.lat);
            chk("stall_cycles", stalls, e.lat);
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
        end
        tick();
        clr();
        @(negedge clk);
        chk("done_single_pulse", {31'd0, md_done}, 32'd0);
    endtask

    initial begin
        bit   seen;
        vec_t v;

        vecs[0]  = '{1'b1, 1'b1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{1'b1, 1'b0, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
        vecs[4]  = '{1'b0, 1'b0, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[5]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{1'b0, 1'b1, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[10] = '{1'b0, 1'b1, 32'd0,        32'd5,        32'h00000000, 32'h00000000};

        // Reset state, with a request presented to show md_stall stays low.
        ex_valid = 1'b1;
        mult     = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_stall", {31'd0, md_stall}, 32'd0);
        chk("reset_done", {31'd0, md_done}, 32'd0);
        clr();
        tick();
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // mthi then mtlo in consecutive cycles.
        tick();
        ex_valid = 1'b1;
        hilowen  = 2'b10;
        rs_val   = 32'hA;
        @(negedge clk);
        chk("mthi_stall", {31'd0, md_stall}, 32'd0);
        tick();
        hilowen = 2'b01;
        rs_val  = 32'hB;
        @(negedge clk);
        chk("mthi_hi", hi, 32'hA);
        chk("mtlo_stall", {31'd0, md_stall}, 32'd0);
        tick();
        clr();
        @(negedge clk);
        chk("mtlo_lo", lo, 32'hB);

        // mthi killed by flush.
        tick();
        ex_valid = 1'b1;
        hilowen  = 2'b10;
        rs_val   = 32'h55;
        flush    = 1'b1;
        tick();
        clr();
        @(negedge clk);
        chk("mthi_flush_hi", hi, 32'hA);

        // Divide flushed while at step 10 (cycle 22 after acceptance).
        tick();
        ex_valid = 1'b1;
        div      = 1'b1;
        mdsign   = 1'b1;
        rs_val   = 32'd100;
        rt_val   = 32'd7;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 1) clr();
        end
        flush = 1'b1;
        @(negedge clk);
        chk("div_busy_stall", {31'd0, md_stall}, 32'd1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("div_flush_stall", {31'd0, md_stall}, 32'd0);
        chk("div_flush_hi", hi, 32'hA);
        chk("div_flush_lo", lo, 32'hB);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (md_done) seen = 1'b1;
        end
        chk("div_flush_no_done", {31'd0, seen}, 32'd0);

        // Multiply flushed in its last busy cycle.
        tick();
        ex_valid = 1'b1;
        mult     = 1'b1;
        mdsign   = 1'b0;
        rs_val   = 32'd7;
        rt_val   = 32'd9;
        tick();
        clr();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("mul_flush_stall", {31'd0, md_stall}, 32'd0);
        chk("mul_flush_hi", hi, 32'hA);
        chk("mul_flush_lo", lo, 32'hB);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (md_done) seen = 1'b1;
        end
        chk("mul_flush_no_done", {31'd0, seen}, 32'd0);

        // Asynchronous reset in the middle of a divide (step 5).
        tick();
        ex_valid = 1'b1;
        div      = 1'b1;
        mdsign   = 1'b1;
        rs_val   = 32'd100;
        rt_val   = 32'd7;
        for (int k = 1; k <= 27; k++) begin
            tick();
            if (k == 1) clr();
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        chk("async_rst_stall", {31'd0, md_stall}, 32'd0);
        chk("async_rst_done", {31'd0, md_done}, 32'd0);
        tick();
        resetn = 1'b1;
        v = '{1'b1, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30};
        run_op(v);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
